// File: rtl/button_hex_counter.sv
// -----------------------------------------------------------------------------
// button_hex_counter
//
// Pushbutton-driven single-digit hex display. Three raw buttons (up, down,
// clear) are brought into the clk domain with a two-flop synchroniser,
// debounced (both edges) and turned into one-cycle press pulses. The pulses
// step a 4-bit wrap-around counter whose value is decoded to an active-low
// seven-segment pattern on the rightmost digit.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles a synchronised level must differ from
//                    the debounced state before that state flips
//   DB_W             width of each debounce counter (2**DB_W > DEBOUNCE_CYCLES)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_up    in   raw up button, active-high, asynchronous to clk
//   btn_down  in   raw down button, active-high, asynchronous to clk
//   btn_clr   in   raw clear button, active-high, asynchronous to clk
//   q         out  current counter value
//   position  out  digit enables, active-low, rightmost digit only (4'b1110)
//   pattern   out  segments {a,b,c,d,e,f,g,dp}, active-low, dp always off
// -----------------------------------------------------------------------------
module button_hex_counter #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DB_W            = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_clr,
   output logic [3:0] q,
   output logic [3:0] position,
   output logic [7:0] pattern
);

   localparam int              NUM_BTN  = 3;
   // The flip happens on the edge where the count would reach
   // DEBOUNCE_CYCLES, i.e. when it currently holds DEBOUNCE_CYCLES-1.
   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

   // Bit order: 0 = up, 1 = down, 2 = clear.
   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] press;

   assign raw = {btn_clr, btn_down, btn_up};

   // ------------------------------------------------------------------
   // Per-button synchroniser, debounce and rising-edge pulse.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         logic            meta;
         logic            sync;
         logic            stable;
         logic            stable_d;
         logic [DB_W-1:0] cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta     <= 1'b0;
               sync     <= 1'b0;
               stable   <= 1'b0;
               stable_d <= 1'b0;
               cnt      <= '0;
            end else begin
               meta     <= raw[gi];
               sync     <= meta;
               stable_d <= stable;
               // Any cycle agreeing with the debounced state restarts the
               // count, so a bounce must settle for the full window.
               if (sync == stable) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  stable <= sync;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
         end

         // High for exactly one cycle per debounced press; release is silent.
         assign press[gi] = stable & ~stable_d;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Counter: clear wins, then up+down cancel, then single step.
   // ------------------------------------------------------------------
   logic [3:0] q_next;

   always_comb begin
      q_next = q;
      if (press[2]) begin
         q_next = 4'h0;
      end else if (press[0] && press[1]) begin
         q_next = q;
      end else if (press[0]) begin
         q_next = q + 4'h1;
      end else if (press[1]) begin
         q_next = q - 4'h1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'h0;
      end else begin
         q <= q_next;
      end
   end

   // ------------------------------------------------------------------
   // Seven-segment decode, registered one cycle behind q.
   // ------------------------------------------------------------------
   logic [7:0] pattern_next;

   always_comb begin
      pattern_next = 8'h03;
      case (q)
         4'h0: pattern_next = 8'h03;
         4'h1: pattern_next = 8'h9F;
         4'h2: pattern_next = 8'h25;
         4'h3: pattern_next = 8'h0D;
         4'h4: pattern_next = 8'h99;
         4'h5: pattern_next = 8'h49;
         4'h6: pattern_next = 8'h41;
         4'h7: pattern_next = 8'h1F;
         4'h8: pattern_next = 8'h01;
         4'h9: pattern_next = 8'h09;
         4'hA: pattern_next = 8'h11;
         4'hB: pattern_next = 8'hC1;
         4'hC: pattern_next = 8'h63;
         4'hD: pattern_next = 8'h85;
         4'hE: pattern_next = 8'h61;
         4'hF: pattern_next = 8'h71;
         default: pattern_next = 8'h03;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern <= 8'h03;
      end else begin
         pattern <= pattern_next;
      end
   end

   // Only the rightmost digit is used; independent of reset.
   assign position = 4'b1110;

endmodule

// File: tb/tb_button_hex_counter.sv
// -----------------------------------------------------------------------------
// tb_button_hex_counter
//
// Directed stimulus drives the raw buttons; for each press it pushes the
// expected new q and the expected pattern, each tagged with the clock edge on
// which it must appear, into a queue. A separate monitor watches q and
// pattern on every falling edge and pops/compares an entry whenever either
// output changes; unexpected changes and overdue entries are both errors.
// -----------------------------------------------------------------------------
module tb_button_hex_counter;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_up;
   logic       btn_down;
   logic       btn_clr;
   logic [3:0] q;
   logic [3:0] position;
   logic [7:0] pattern;

   button_hex_counter #(
      .DEBOUNCE_CYCLES(N),
      .DB_W           (20)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_up  (btn_up),
      .btn_down(btn_down),
      .btn_clr (btn_clr),
      .q       (q),
      .position(position),
      .pattern (pattern)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_pat;
      logic [7:0] val;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         cyc     = 0;
   int         n_vec   = 0;
   int         n_bad   = 0;
   bit         mon_en  = 1'b0;
   logic [3:0] model_q = 4'h0;

   // Count of rising edges so far; read on falling edges only.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] seg(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'h0: s = 8'h03;  4'h1: s = 8'h9F;  4'h2: s = 8'h25;  4'h3: s = 8'h0D;
         4'h4: s = 8'h99;  4'h5: s = 8'h49;  4'h6: s = 8'h41;  4'h7: s = 8'h1F;
         4'h8: s = 8'h01;  4'h9: s = 8'h09;  4'hA: s = 8'h11;  4'hB: s = 8'hC1;
         4'hC: s = 8'h63;  4'hD: s = 8'h85;  4'hE: s = 8'h61;  default: s = 8'h71;
      endcase
      return s;
   endfunction

   task automatic push_exp(input bit is_pat, input logic [7:0] val, input int at);
      exp_t e;
      e.is_pat = is_pat;
      e.val    = val;
      e.cyc    = at;
      exp_q.push_back(e);
   endtask

   // q changes on edge t0+N+3 and pattern on t0+N+4, where t0 is the edge
   // count at the falling edge on which the raw button was driven.
   task automatic expect_step(input logic [3:0] nq, input int t0);
      push_exp(1'b0, {4'h0, nq}, t0 + N + 3);
      push_exp(1'b1, seg(nq), t0 + N + 4);
      model_q = nq;
   endtask

   task automatic direct_check(input string name, input logic [7:0] got,
                               input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end else begin
         $display("vec %0d %s ok: %h", n_vec, name, got);
      end
   endtask

   // Clean press of any button combination; returns at a falling edge.
   task automatic press(input logic u, input logic d, input logic c,
                        input int hold, input int gap);
      logic [3:0] nq;
      nq = model_q;
      if (c)           nq = 4'h0;
      else if (u && d) nq = model_q;
      else if (u)      nq = model_q + 4'h1;
      else if (d)      nq = model_q - 4'h1;
      btn_up   = u;
      btn_down = d;
      btn_clr  = c;
      if (nq != model_q) expect_step(nq, cyc);
      repeat (hold) @(negedge clk);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_clr  = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   task automatic check_evt(input bit is_pat, input logic [7:0] got);
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got %h at edge %0d, none expected",
                  is_pat ? "pattern" : "q", got, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.is_pat != is_pat || e.val !== got || e.cyc != cyc
             || position !== 4'b1110) begin
            n_bad++;
            $display("FAIL event_%s: got %h at edge %0d pos %b, want %s %h at edge %0d pos 1110",
                     is_pat ? "pattern" : "q", got, cyc, position,
                     e.is_pat ? "pattern" : "q", e.val, e.cyc);
         end else begin
            $display("vec %0d %s=%h at edge %0d ok", n_vec,
                     is_pat ? "pattern" : "q", got, cyc);
         end
      end
   endtask

   initial begin
      logic [3:0] last_q;
      logic [7:0] last_pat;
      exp_t       e;
      last_q   = 4'h0;
      last_pat = 8'h00;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (q !== last_q)         check_evt(1'b0, {4'h0, q});
            if (pattern !== last_pat) check_evt(1'b1, pattern);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               n_vec++;
               n_bad++;
               $display("FAIL missing_%s: want %h at edge %0d, not seen by edge %0d",
                        e.is_pat ? "pattern" : "q", e.val, e.cyc, cyc);
            end
         end
         last_q   = q;
         last_pat = pattern;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      logic b_seq [6];
      b_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      rst_n    = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_clr  = 1'b0;
      repeat (3) @(negedge clk);
      direct_check("reset_position", {4'h0, position}, 8'h0E);
      direct_check("reset_q", {4'h0, q}, 8'h00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      direct_check("post_reset_q", {4'h0, q}, 8'h00);
      direct_check("post_reset_pattern", pattern, 8'h03);
      direct_check("post_reset_position", {4'h0, position}, 8'h0E);
      mon_en = 1'b1;
      repeat (10) @(negedge clk);   // idle: any output change is flagged

      // Single long press: one step, nothing on release.
      press(1'b1, 1'b0, 1'b0, 20, 12);

      // Bounce: short runs never reach the window, final hold steps once.
      for (int i = 0; i < 6; i++) begin
         btn_up = b_seq[i];
         @(negedge clk);
      end
      btn_up = 1'b1;
      expect_step(model_q + 4'h1, cyc);
      repeat (10) @(negedge clk);
      btn_up = 1'b0;
      repeat (12) @(negedge clk);

      // Wrap up through F back to 0, then down wrap 0 -> F.
      press(1'b0, 1'b0, 1'b1, 8, 10);
      for (int i = 0; i < 16; i++) press(1'b1, 1'b0, 1'b0, 8, 10);
      press(1'b0, 1'b1, 1'b0, 8, 10);

      // Simultaneous presses from q=5.
      press(1'b0, 1'b0, 1'b1, 8, 10);
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, 8, 10);
      press(1'b1, 1'b1, 1'b0, 8, 10);   // cancel: no change
      press(1'b1, 1'b0, 1'b1, 8, 10);   // clear wins

      // Reset mid-press at q=3, button still held afterwards.
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0, 8, 10);
      btn_down = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      push_exp(1'b0, 8'h00, cyc);
      push_exp(1'b1, 8'h03, cyc);
      model_q = 4'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_step(4'hF, cyc);
      repeat (12) @(negedge clk);
      btn_down = 1'b0;
      repeat (12) @(negedge clk);

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected events still pending, want 0", exp_q.size());
      end
      direct_check("final_q", {4'h0, q}, {4'h0, model_q});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
